// File: rtl/test_controller_if.sv
// -----------------------------------------------------------------------------
// test_controller_if
// CPU data-memory bus as seen by the test controller.
//   mem_wr_sig   CPU write strobe
//   mem_addr     CPU byte address
//   mem_wr_data  CPU write data
//   mem_rd_data  read data returned for window addresses (0 elsewhere)
//   hit          address lies inside the controller's register window
// master = CPU side, slave = test controller side.
// -----------------------------------------------------------------------------
interface test_controller_if;
  logic        mem_wr_sig;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        hit;

  modport master (
    output mem_wr_sig, mem_addr, mem_wr_data,
    input  mem_rd_data, hit
  );

  modport slave (
    input  mem_wr_sig, mem_addr, mem_wr_data,
    output mem_rd_data, hit
  );
endinterface

// File: rtl/test_controller.sv
// -----------------------------------------------------------------------------
// test_controller
// Test-control peripheral on the CPU data bus. The program reports pass/fail
// through TOHOST, pushes result words into a signature FIFO, and a cycle
// counter with a timeout ends a hung run in a defined TIMEOUT state.
//
// Register window (BASE_ADDR + offset, addr[1:0] ignored):
//   0x0 TOHOST    W  1 -> PASS, other nonzero -> FAIL, 0 ignored
//   0x4 SIGNATURE W  push into signature FIFO (RUN only)
//   0x8 CYCLE     R  zero-extended cycle_count
//   0xC STATUS    R  {26'b0, sig_overflow, sig_empty, timeout, fail, pass, done}
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           CPU data bus (slave modport)
//   done/pass/fail/timeout   run state decode
//   fail_code     data[31:1] of the failing TOHOST write
//   cycle_count   edges spent in RUN (saturating)
//   sig_rd_en     bench pop strobe
//   sig_rd_data   FIFO head (first-word fall-through)
//   sig_count, sig_empty, sig_overflow   FIFO status
// -----------------------------------------------------------------------------
module test_controller #(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned SIG_DEPTH      = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  test_controller_if.slave             bus,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [30:0]                  fail_code,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  input  logic                         sig_rd_en,
  output logic [31:0]                  sig_rd_data,
  output logic [$clog2(SIG_DEPTH):0]   sig_count,
  output logic                         sig_empty,
  output logic                         sig_overflow
);

  localparam int unsigned AW = $clog2(SIG_DEPTH);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Timeout fires on the edge where the count still holds the last RUN value.
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(SIG_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t                 r_state, w_state_next;
  logic [CNT_WIDTH-1:0]   r_cycle_count;
  logic [30:0]            r_fail_code;
  logic [31:0]            r_mem [SIG_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;

  logic                   w_hit, w_tohost_wr, w_sig_wr;
  logic [1:0]             w_offset;
  logic                   w_push_req, w_do_push, w_do_pop;
  logic [31:0]            w_rd_data;
  logic                   w_unused;

  // ---------------------------------------------------------------- decode
  assign w_hit       = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_offset    = bus.mem_addr[3:2];
  assign w_tohost_wr = w_hit && bus.mem_wr_sig && (w_offset == 2'd0);
  assign w_sig_wr    = w_hit && bus.mem_wr_sig && (w_offset == 2'd1);
  assign w_unused    = ^bus.mem_addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    if (r_state == ST_RUN) begin
      // A state-changing TOHOST write takes priority over the timeout edge.
      if (w_tohost_wr && bus.mem_wr_data == 32'd1)
        w_state_next = ST_PASS;
      else if (w_tohost_wr && bus.mem_wr_data != 32'd0)
        w_state_next = ST_FAIL;
      else if (TIMEOUT_EN && r_cycle_count == TIMEOUT_LAST)
        w_state_next = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_fail_code <= '0;
    else if (r_state == ST_RUN && w_state_next == ST_FAIL)
      r_fail_code <= bus.mem_wr_data[31:1];
  end

  // Counts every RUN edge, frozen in terminal states, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      r_cycle_count <= '0;
    else if (r_state == ST_RUN && r_cycle_count != '1)
      r_cycle_count <= r_cycle_count + 1'b1;
  end

  // ---------------------------------------------------------------- FIFO
  assign w_push_req = w_sig_wr && (r_state == ST_RUN);
  assign w_do_pop   = sig_rd_en && (r_count != '0);
  // When full, a push is only accepted if a pop frees the head this edge.
  assign w_do_push  = w_push_req && ((r_count != FIFO_FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      if (w_push_req && !w_do_push) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; resetting the pointers/count discards contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= bus.mem_wr_data;
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    w_rd_data = '0;
    if (w_hit) begin
      case (w_offset)
        2'd2:    w_rd_data = 32'(r_cycle_count);
        2'd3:    w_rd_data = {26'b0, r_overflow, sig_empty, timeout, fail, pass, done};
        default: w_rd_data = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.hit         = w_hit;
  assign bus.mem_rd_data = w_rd_data;

  assign done         = (r_state != ST_RUN);
  assign pass         = (r_state == ST_PASS);
  assign fail         = (r_state == ST_FAIL);
  assign timeout      = (r_state == ST_TIMEOUT);
  assign fail_code    = r_fail_code;
  assign cycle_count  = r_cycle_count;
  assign sig_rd_data  = r_mem[r_rd_ptr];
  assign sig_count    = r_count;
  assign sig_empty    = (r_count == '0);
  assign sig_overflow = r_overflow;

endmodule

// File: tb/tb_test_controller.sv
// -----------------------------------------------------------------------------
// tb_test_controller
// Self-checking bench for test_controller. Inputs are driven and outputs
// sampled on the falling edge. Signature words are tracked in a scoreboard
// queue: pushed when an accepted SIGNATURE write is driven, popped and
// compared against sig_rd_data when the bench pops the FIFO.
// -----------------------------------------------------------------------------
module tb_test_controller;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_rd_en;
  logic        done, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic [31:0] sig_rd_data;
  logic [4:0]  sig_count;
  logic        sig_empty, sig_overflow;

  test_controller_if bus ();

  test_controller dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .sig_rd_en    (sig_rd_en),
    .sig_rd_data  (sig_rd_data),
    .sig_count    (sig_count),
    .sig_empty    (sig_empty),
    .sig_overflow (sig_overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  logic        exp_ovf;
  logic        exp_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input logic ovf, input logic empty,
                                              input logic to, input logic f,
                                              input logic p, input logic d);
    return {26'b0, ovf, empty, to, f, p, d};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.mem_wr_sig = 1'b0;
    sig_rd_en      = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_run = 1'b1;
  endtask

  // One bus edge: optional write and optional pop, with the scoreboard updated
  // from the bench's own view of the FIFO occupancy and run state.
  task automatic bus_op(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic pop);
    int   n_before;
    logic pop_ok;
    logic in_win;
    n_before = sb.size();
    pop_ok   = pop && (n_before != 0);
    in_win   = (addr[31:4] == BASE[31:4]);
    if (pop_ok) begin
      check("sig_head", sig_rd_data, sb[0]);
      void'(sb.pop_front());
    end
    if (wr && in_win && addr[3:2] == 2'd1 && exp_run) begin
      if (n_before < DEPTH || pop_ok) sb.push_back(data);
      else                            exp_ovf = 1'b1;
    end
    if (wr && in_win && addr[3:2] == 2'd0 && exp_run && data != 32'd0)
      exp_run = 1'b0;
    bus.mem_wr_sig  = wr;
    bus.mem_addr    = addr;
    bus.mem_wr_data = data;
    sig_rd_en       = pop;
    @(negedge clk);
    bus.mem_wr_sig = 1'b0;
    sig_rd_en      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic h);
    bus.mem_wr_sig = 1'b0;
    bus.mem_addr   = addr;
    #1;
    data = bus.mem_rd_data;
    h    = bus.hit;
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, sig_count, sb.size());
    check({tag, "_empty"}, sig_empty, sb.size() == 0);
    check({tag, "_ovf"},   sig_overflow, exp_ovf);
  endtask

  task automatic check_state(input string tag, input logic d, input logic p,
                             input logic f, input logic t);
    check({tag, "_done"},    done,    d);
    check({tag, "_pass"},    pass,    p);
    check({tag, "_fail"},    fail,    f);
    check({tag, "_timeout"}, timeout, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        h;
    logic [31:0] wide;

    reset           = 1'b1;
    sig_rd_en       = 1'b0;
    bus.mem_wr_sig  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    exp_ovf         = 1'b0;
    exp_run         = 1'b1;
    idle(2);

    // ---- reset state and address decode
    do_reset();
    check_state("rst", 0, 0, 0, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_fail_code", fail_code, 0);
    check_fifo("rst");
    bus_read(BASE + 32'hB, rd, h);
    check("rd_cycle_lowbits", rd, 0);
    check("hit_cycle", h, 1);
    bus_read(BASE + 32'hC, rd, h);
    check("rd_status_rst", rd, status_word(0, 1, 0, 0, 0, 0));
    bus_read(BASE, rd, h);
    check("rd_tohost", rd, 0);
    bus_read(BASE + 32'h10, rd, h);
    check("hit_above", h, 0);
    check("rd_above", rd, 0);
    bus_read(BASE - 32'h4, rd, h);
    check("hit_below", h, 0);
    bus_op(1, BASE + 32'h10, 32'd1, 0);
    check("outside_wr_ignored", done, 0);

    // ---- PASS at cycle 20
    do_reset();
    idle(20);
    check("pass_pre_cycle", cycle_count, 20);
    bus_op(1, BASE, 32'd1, 0);
    check_state("pass", 1, 1, 0, 0);
    check("pass_cycle", cycle_count, 21);
    idle(5);
    check("pass_cycle_frozen", cycle_count, 21);
    bus_op(1, BASE + 32'h4, 32'h55, 0);
    check_fifo("pass_sig_ignored");
    bus_read(BASE + 32'h8, rd, h);
    check("pass_rd_cycle", rd, 21);
    bus_read(BASE + 32'hC, rd, h);
    check("pass_rd_status", rd, status_word(0, 1, 0, 0, 1, 1));

    // ---- FAIL, then terminal
    do_reset();
    bus_op(1, BASE, 32'd0, 0);
    check("zero_tohost_ignored", done, 0);
    bus_op(1, BASE, 32'h0000_0007, 0);
    check_state("fail", 1, 0, 1, 0);
    check("fail_code7", fail_code, 31'd3);
    bus_op(1, BASE, 32'd1, 0);
    check_state("fail_sticky", 1, 0, 1, 0);
    check("fail_code_sticky", fail_code, 31'd3);

    do_reset();
    wide = 32'hDEAD_BEEF;
    bus_op(1, BASE + 32'h2, wide, 0);
    check("fail_code_wide", fail_code, wide[31:1]);

    // ---- TIMEOUT
    do_reset();
    idle(499);
    check("to_pre", timeout, 0);
    check("to_pre_cycle", cycle_count, 499);
    idle(1);
    exp_run = 1'b0;
    check_state("to", 1, 0, 0, 1);
    check("to_cycle", cycle_count, 500);
    idle(10);
    check("to_cycle_frozen", cycle_count, 500);
    bus_read(BASE + 32'hC, rd, h);
    check("to_rd_status", rd, status_word(0, 1, 1, 0, 0, 1));
    bus_read(BASE + 32'h8, rd, h);
    check("to_rd_cycle", rd, 500);

    // ---- TOHOST at the timeout edge wins
    do_reset();
    idle(499);
    bus_op(1, BASE, 32'd1, 0);
    check_state("edge_pass", 1, 1, 0, 0);
    check("edge_cycle", cycle_count, 500);
    idle(3);
    check("edge_no_timeout", timeout, 0);

    // ---- FIFO overflow and ordered drain
    do_reset();
    for (int i = 0; i < 17; i++) bus_op(1, BASE + 32'h4, 32'hA0 + i, 0);
    check_fifo("ovf_full");
    for (int i = 0; i < 16; i++) bus_op(0, BASE, 32'd0, 1);
    check_fifo("ovf_drained");
    bus_op(0, BASE, 32'd0, 1);
    check_fifo("pop_empty");

    // ---- full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) bus_op(1, BASE + 32'h4, 32'hB0 + i, 0);
    check_fifo("pp_full");
    bus_op(1, BASE + 32'h4, 32'hC0, 1);
    check_fifo("pp_after");
    for (int i = 0; i < 16; i++) bus_op(0, BASE, 32'd0, 1);
    check_fifo("pp_drained");

    // ---- reset mid-run with words queued
    do_reset();
    for (int i = 0; i < 5; i++) bus_op(1, BASE + 32'h4, 32'hD0 + i, 0);
    check_fifo("mid_queued");
    idle(94);
    check("mid_pre_cycle", cycle_count, 99);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_run = 1'b1;
    check("mid_cycle", cycle_count, 0);
    check_state("mid", 0, 0, 0, 0);
    check_fifo("mid_reset");
    bus_op(1, BASE + 32'h4, 32'hE0, 0);
    bus_op(0, BASE, 32'd0, 1);
    check_fifo("mid_fresh");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
